// File: rtl/readout_scheduler_if.sv
// Readout scheduler bus: channel request/done lines, readout mux address and
// serial return, and the valid/ready byte stream.
interface readout_scheduler_if #(
    parameter int NUM_CH = 8
);
    logic [NUM_CH-1:0] ch_ready;
    logic              poci;
    logic [6:0]        addr;
    logic              cs;
    logic [7:0]        out_data;
    logic [2:0]        out_ch;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic [NUM_CH-1:0] ch_done;
    logic              busy;

    // The scheduler side drives the mux and the output stream.
    modport master (
        input  ch_ready, poci, out_ready,
        output addr, cs, out_data, out_ch, out_last, out_valid, ch_done, busy
    );

    // Channels, readout mux and stream consumer.
    modport slave (
        output ch_ready, poci, out_ready,
        input  addr, cs, out_data, out_ch, out_last, out_valid, ch_done, busy
    );
endinterface

// File: rtl/readout_scheduler.sv
// Round-robin readout scheduler: grants one requesting channel at a time,
// walks its register block through the readout mux, deserialises each
// register MSB first and hands the bytes out on a valid/ready stream.
module readout_scheduler #(
    parameter int NUM_CH            = 8,
    parameter int CH_REG_START_ADDR = 12,
    parameter int NUM_REGS_PER_CH   = 7,
    parameter int BITS_PER_REG      = 8
) (
    input  logic                   spi_clk,
    input  logic                   rst,
    readout_scheduler_if.master    bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RI_W = (NUM_REGS_PER_CH > 1) ? $clog2(NUM_REGS_PER_CH) : 1;
    localparam int BC_W = (BITS_PER_REG > 1) ? $clog2(BITS_PER_REG) : 1;
    localparam logic [RI_W-1:0] LAST_REG = RI_W'(NUM_REGS_PER_CH - 1);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(BITS_PER_REG - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        OUTPUT,
        RELEASE
    } state_t;

    state_t                  state;
    logic [CH_W-1:0]         grant;
    logic [CH_W-1:0]         last_grant;
    logic [CH_W-1:0]         pick;
    logic [RI_W-1:0]         reg_idx;
    logic [BC_W-1:0]         bit_cnt;
    logic [BITS_PER_REG-1:0] shreg;
    logic [6:0]              addr_q;
    logic                    cs_q;
    logic [7:0]              out_data_q;
    logic [2:0]              out_ch_q;
    logic                    out_last_q;
    logic                    out_valid_q;
    logic [NUM_CH-1:0]       ch_done_q;
    logic                    busy_q;

    // Register address of a channel's register, wrapped to the 7-bit mux space.
    function automatic logic [6:0] reg_addr(input logic [CH_W-1:0] ch,
                                            input logic [RI_W-1:0] idx);
        return 7'(CH_REG_START_ADDR) + 7'(ch) * 7'(NUM_REGS_PER_CH) + 7'(idx);
    endfunction

    // First requesting channel after the previous grant, wrapping around.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [CH_W-1:0] last);
        logic [NUM_CH-1:0] rot;
        int                off;
        logic              found;
        rot   = req;
        off   = 0;
        found = 1'b0;
        // Rotate so that bit 0 is the channel just after the last grant.
        for (int i = 0; i < NUM_CH; i++) begin
            if (i <= int'(last)) rot = {rot[0], rot[NUM_CH-1:1]};
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && rot[0]) begin
                found = 1'b1;
                off   = i;
            end
            rot = {rot[0], rot[NUM_CH-1:1]};
        end
        return CH_W'((int'(last) + 1 + off) % NUM_CH);
    endfunction

    assign pick = rr_pick(bus.ch_ready, last_grant);

    // Scheduler FSM; every output is a register so out_valid never follows out_ready.
    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            last_grant  <= CH_W'(NUM_CH - 1);
            reg_idx     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            addr_q      <= '0;
            cs_q        <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ch_done_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            ch_done_q <= '0;
            unique case (state)
                IDLE: begin
                    if (|bus.ch_ready) begin
                        grant   <= pick;
                        reg_idx <= '0;
                        addr_q  <= reg_addr(pick, '0);
                        cs_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    // Mux needs one cycle after the address before data appears.
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    shreg   <= {shreg[BITS_PER_REG-2:0], bus.poci};
                    bit_cnt <= bit_cnt + BC_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        out_data_q  <= 8'({shreg[BITS_PER_REG-2:0], bus.poci});
                        out_ch_q    <= 3'(grant);
                        out_last_q  <= (reg_idx == LAST_REG);
                        out_valid_q <= 1'b1;
                        state       <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (reg_idx != LAST_REG) begin
                            // Next register of the same channel; cs stays high.
                            reg_idx <= reg_idx + RI_W'(1);
                            addr_q  <= reg_addr(grant, reg_idx + RI_W'(1));
                            state   <= SETUP;
                        end else begin
                            ch_done_q  <= NUM_CH'(1) << grant;
                            last_grant <= grant;
                            reg_idx    <= '0;
                            addr_q     <= '0;
                            cs_q       <= 1'b0;
                            state      <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.addr      = addr_q;
    assign bus.cs        = cs_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ch_done   = ch_done_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_readout_scheduler.sv
// Bench for readout_scheduler: a readout mux model serves random register
// contents, a round-robin grant model predicts the channel order, and every
// byte, address, latency and done pulse is compared against that prediction.
module tb_readout_scheduler;
    localparam int NUM_CH = 8;
    localparam int START  = 12;
    localparam int NREG   = 7;
    localparam int BITS   = 8;

    logic spi_clk = 1'b0;
    logic rst     = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [128];
    int         model_last;
    bit         rdy_hold = 1'b0;
    bit         scramble = 1'b0;

    readout_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

    readout_scheduler #(
        .NUM_CH(NUM_CH),
        .CH_REG_START_ADDR(START),
        .NUM_REGS_PER_CH(NREG),
        .BITS_PER_REG(BITS)
    ) dut (
        .spi_clk(spi_clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 spi_clk = ~spi_clk;

    // Readout mux: data for a new address starts one cycle after it is presented,
    // MSB first; outside that window the line carries noise.
    int         mux_cnt = 0;
    logic       mux_prev_cs = 1'b0;
    logic [6:0] mux_prev_addr = '0;
    logic [7:0] mux_byte;
    always @(negedge spi_clk) begin
        if (!bus.cs || !mux_prev_cs || bus.addr != mux_prev_addr) begin
            mux_cnt  = 0;
            bus.poci = 1'($urandom);
        end else begin
            mux_cnt = mux_cnt + 1;
            if (mux_cnt <= BITS) begin
                mux_byte = mem[bus.addr];
                bus.poci = mux_byte[3'(BITS - mux_cnt)];
            end else begin
                bus.poci = 1'($urandom);
            end
        end
        mux_prev_cs   = bus.cs;
        mux_prev_addr = bus.addr;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed no end of run, required finish within budget");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_grant(input int last, input logic [7:0] req);
        for (int i = 1; i <= NUM_CH; i++) begin
            int c;
            c = (last + i) % NUM_CH;
            if (((req >> c) & 8'd1) != 8'd0) return c;
        end
        return -1;
    endfunction

    task automatic scramble_mem();
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_cs"}, 32'(bus.cs), 0);
        check({tag, "_addr"}, 32'(bus.addr), 0);
        check({tag, "_done"}, 32'(bus.ch_done), 0);
    endtask

    task automatic run_regs(input int ch, input int nregs, input int first_stall);
        for (int r = 0; r < nregs; r++) begin
            int exp_addr;
            int start;
            int n;
            int stall;
            bit found;
            exp_addr = START + ch * NREG + r;
            start    = -1;
            n        = 0;
            found    = 1'b0;
            while (n < 60 && !found) begin
                if (bus.cs && int'(bus.addr) == exp_addr && start < 0) start = n;
                if (bus.out_valid) begin
                    found = 1'b1;
                end else begin
                    @(negedge spi_clk);
                    n++;
                    if (scramble) bus.ch_ready = 8'($urandom);
                end
            end
            check("valid_seen", 32'(found), 1);
            if (!found) return;
            check("latency", (start < 0) ? 32'hFFFF_FFFF : 32'(n - start), 32'(1 + BITS));
            check("data", 32'(bus.out_data), 32'(mem[7'(exp_addr)]));
            check("ch", 32'(bus.out_ch), 32'(ch));
            check("last", 32'(bus.out_last), 32'(r == NREG - 1));
            check("addr", 32'(bus.addr), 32'(exp_addr));
            check("out_cs", 32'(bus.cs), 1);
            check("out_busy", 32'(bus.busy), 1);
            check("out_done", 32'(bus.ch_done), 0);
            if (!rdy_hold) begin
                stall = (r == 0 && first_stall > 0) ? first_stall : int'($urandom_range(0, 2));
                repeat (stall) begin
                    @(negedge spi_clk);
                    if (scramble) bus.ch_ready = 8'($urandom);
                    check("stall_valid", 32'(bus.out_valid), 1);
                    check("stall_data", 32'(bus.out_data), 32'(mem[7'(exp_addr)]));
                    check("stall_addr", 32'(bus.addr), 32'(exp_addr));
                end
                bus.out_ready = 1'b1;
                @(negedge spi_clk);
                bus.out_ready = 1'b0;
            end else begin
                @(negedge spi_clk);
            end
            if (r < NREG - 1) begin
                check("next_valid", 32'(bus.out_valid), 0);
                check("next_cs", 32'(bus.cs), 1);
            end
        end
    endtask

    task automatic do_channel(input int ch, input int first_stall, input logic [7:0] next_req);
        run_regs(ch, NREG, first_stall);
        check("rel_done", 32'(bus.ch_done), 32'(1) << ch);
        check("rel_cs", 32'(bus.cs), 0);
        check("rel_addr", 32'(bus.addr), 0);
        check("rel_valid", 32'(bus.out_valid), 0);
        check("rel_last", 32'(bus.out_last), 0);
        check("rel_busy", 32'(bus.busy), 1);
        model_last    = ch;
        bus.ch_ready  = next_req;
        @(negedge spi_clk);
        check_idle("gap");
    endtask

    initial begin
        int         ch;
        logic [7:0] req;
        logic [7:0] nreq;

        bus.ch_ready  = '0;
        bus.out_ready = 1'b0;
        scramble_mem();
        rst = 1'b1;
        repeat (3) @(negedge spi_clk);
        check_idle("reset");
        check("reset_valid", 32'(bus.out_valid), 0);
        check("reset_data", 32'(bus.out_data), 0);
        check("reset_ch", 32'(bus.out_ch), 0);
        check("reset_last", 32'(bus.out_last), 0);
        rst = 1'b0;
        model_last = NUM_CH - 1;

        // No requests: scheduler must sit idle.
        repeat (20) begin
            @(negedge spi_clk);
            check_idle("no_req");
        end

        // Single channel 0, constant pattern 0xA5, consumer always ready.
        for (int a = START; a < START + NREG; a++) mem[a] = 8'hA5;
        rdy_hold      = 1'b1;
        bus.out_ready = 1'b1;
        req           = 8'h01;
        bus.ch_ready  = req;
        ch = next_grant(model_last, req);
        do_channel(ch, 0, 8'h00);
        rdy_hold      = 1'b0;
        bus.out_ready = 1'b0;

        // Fresh reset so channel 0 has first priority again.
        rst = 1'b1;
        @(negedge spi_clk);
        rst = 1'b0;
        model_last = NUM_CH - 1;
        scramble_mem();

        // All channels requesting: full rotation, first byte stalled 5 cycles.
        req          = 8'hFF;
        bus.ch_ready = req;
        for (int k = 0; k < 9; k++) begin
            ch   = next_grant(model_last, req);
            nreq = (k == 8) ? 8'h04 : 8'hFF;
            do_channel(ch, (k == 0) ? 5 : 0, nreq);
            req = nreq;
        end

        // Channel 2 then {2,5}: round robin must move on to 5.
        ch = next_grant(model_last, req);
        do_channel(ch, 0, 8'h24);
        req  = 8'h24;
        ch   = next_grant(model_last, req);
        nreq = 8'($urandom_range(1, 255));
        do_channel(ch, 0, nreq);
        req = nreq;

        // Random requests, random register data, requests churn mid-transfer.
        scramble = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ch   = next_grant(model_last, req);
            nreq = (k == 5) ? 8'h10 : 8'($urandom_range(1, 255));
            do_channel(ch, 0, nreq);
            req = nreq;
        end
        scramble = 1'b0;

        // Abort channel 4 in the middle of shifting register 3.
        ch = next_grant(model_last, req);
        run_regs(ch, 3, 0);
        check("abort_addr", 32'(bus.addr), 32'(START + ch * NREG + 3));
        repeat (3) @(negedge spi_clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle("abort");
        check("abort_valid", 32'(bus.out_valid), 0);
        check("abort_data", 32'(bus.out_data), 0);
        check("abort_last", 32'(bus.out_last), 0);
        @(negedge spi_clk);
        check("abort_done_hold", 32'(bus.ch_done), 0);
        rst = 1'b0;
        model_last = NUM_CH - 1;
        ch = next_grant(model_last, req);
        do_channel(ch, 0, 8'h00);

        repeat (10) begin
            @(negedge spi_clk);
            check_idle("final_idle");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
